mips_alu_unit: RTL and testbench

Execute-stage arithmetic block of the single-cycle MIPS CPU. Combines the ALU-control decoder (ALUOp/funct to a 4-bit operation code), the 32-bit MIPS ALU with zero/carry/overflow flags, and the free-running PC+4 adder. All datapath results are combinational within the cycle. The only state is a sticky overflow status register.

---
 rtl/mips_alu_pkg.sv | 28 ++
 rtl/mips_alu_ctl_dec.sv | 33 +++
 rtl/mips_alu_unit.sv | 97 +++++++++
 tb/tb_mips_alu_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operation codes,
// main-control alu_op values and R-type funct fields.
package mips_alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
   localparam logic [1:0] ALU_OP_SLT   = 2'b11;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/mips_alu_ctl_dec.sv
// ALU-control decoder: maps main-control alu_op and the R-type funct
// field to the 4-bit ALU operation code. Purely combinational.
module mips_alu_ctl_dec
   import mips_alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctl
);

   always_comb begin
      alu_ctl = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD: alu_ctl = ALU_ADD;
         ALU_OP_SUB: alu_ctl = ALU_SUB;
         ALU_OP_SLT: alu_ctl = ALU_SLT;
         default: begin
            // Unlisted funct codes fall back to ADD so the datapath stays defined.
            case (funct)
               FUNCT_ADD, FUNCT_ADDU: alu_ctl = ALU_ADD;
               FUNCT_SUB, FUNCT_SUBU: alu_ctl = ALU_SUB;
               FUNCT_AND:             alu_ctl = ALU_AND;
               FUNCT_OR:              alu_ctl = ALU_OR;
               FUNCT_XOR:             alu_ctl = ALU_XOR;
               FUNCT_NOR:             alu_ctl = ALU_NOR;
               FUNCT_SLT:             alu_ctl = ALU_SLT;
               default:               alu_ctl = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mips_alu_unit.sv
// Execute-stage arithmetic: ALU-control decode, 32-bit ALU with flags,
// PC+4 adder and a sticky overflow status bit (the only clocked state).
module mips_alu_unit
   import mips_alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  alu_op,
   input  logic [5:0]  funct,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [3:0]  alu_ctl,
   output logic [31:0] alu_res,
   output logic        zero,
   output logic        cout,
   output logic        ovf,
   output logic        ovf_sticky,
   input  logic [31:0] pc_in,
   output logic [31:0] pc_sum
);

   logic [32:0] add_sum;
   logic [32:0] sub_sum;
   logic        add_ovf;
   logic        sub_ovf;
   logic [31:0] and_v;
   logic [31:0] or_v;
   logic [31:0] xor_v;
   logic [31:0] nor_v;
   logic        ovf_sticky_reg;
   logic        ovf_sticky_next;

   mips_alu_ctl_dec u_ctl_dec (
      .alu_op  (alu_op),
      .funct   (funct),
      .alu_ctl (alu_ctl)
   );

   assign add_sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
   // Subtraction as a + ~b + 1, so cout=1 signals "no borrow".
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
   assign add_ovf = (a[31] == b[31]) && (add_sum[31] != a[31]);
   assign sub_ovf = (a[31] != b[31]) && (sub_sum[31] != a[31]);

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_logic
         assign and_v[gi] = a[gi] & b[gi];
         assign or_v[gi]  = a[gi] | b[gi];
         assign xor_v[gi] = a[gi] ^ b[gi];
         assign nor_v[gi] = ~(a[gi] | b[gi]);
      end
   endgenerate

   always_comb begin
      alu_res = 32'd0;
      cout    = 1'b0;
      ovf     = 1'b0;
      case (alu_ctl)
         ALU_ADD: begin
            alu_res = add_sum[31:0];
            cout    = add_sum[32];
            ovf     = add_ovf;
         end
         ALU_SUB: begin
            alu_res = sub_sum[31:0];
            cout    = sub_sum[32];
            ovf     = sub_ovf;
         end
         // Sign of the difference corrected by its overflow gives a true signed compare.
         ALU_SLT: alu_res = {31'd0, sub_sum[31] ^ sub_ovf};
         ALU_AND: alu_res = and_v;
         ALU_OR:  alu_res = or_v;
         ALU_XOR: alu_res = xor_v;
         ALU_NOR: alu_res = nor_v;
         default: alu_res = 32'd0;
      endcase
   end

   assign zero   = (alu_res == 32'd0);
   assign pc_sum = pc_in + 32'd4;

   always_comb begin
      ovf_sticky_next = ovf_sticky_reg | ovf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_sticky_reg <= 1'b0;
      end else begin
         ovf_sticky_reg <= ovf_sticky_next;
      end
   end

   assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_mips_alu_unit.sv
// Self-checking bench for mips_alu_unit: directed corner cases plus
// randomized operations against an integer-arithmetic reference model.
module tb_mips_alu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_res;
   logic        zero;
   logic        cout;
   logic        ovf;
   logic        ovf_sticky;
   logic [31:0] pc_in;
   logic [31:0] pc_sum;

   int errors = 0;
   int checks = 0;
   logic exp_sticky = 1'b0;

   always #5 clk = ~clk;

   mips_alu_unit dut (
      .clk        (clk),
      .reset      (reset),
      .alu_op     (alu_op),
      .funct      (funct),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .alu_ctl    (alu_ctl),
      .alu_res    (alu_res),
      .zero       (zero),
      .cout       (cout),
      .ovf        (ovf),
      .ovf_sticky (ovf_sticky),
      .pc_in      (pc_in),
      .pc_sum     (pc_sum)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference decode written as a lookup over the funct table.
   function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [5:0] fn);
      logic [5:0] fn_tab [9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
      logic [3:0] ctl_tab [9] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7};
      if (op == 2'b00) return 4'h2;
      if (op == 2'b01) return 4'h6;
      if (op == 2'b11) return 4'h7;
      for (int i = 0; i < 9; i++)
         if (fn_tab[i] == fn) return ctl_tab[i];
      return 4'h2;
   endfunction

   // Reference datapath using wide signed/unsigned integer arithmetic.
   task automatic ref_alu(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, output logic [31:0] r, output logic co, output logic ov);
      longint sx, sy, s;
      longint unsigned u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r = 32'd0; co = 1'b0; ov = 1'b0;
      case (ctl)
         4'h2: begin
            u  = longint'(x) + longint'(y) + longint'(ci);
            s  = sx + sy + longint'(ci);
            r  = u[31:0];
            co = u[32];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'h6: begin
            s  = sx - sy;
            r  = x - y;
            co = (x >= y);
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'h7: r = (sx < sy) ? 32'd1 : 32'd0;
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h3: r = x ^ y;
         4'hC: r = ~(x | y);
         default: r = 32'd0;
      endcase
   endtask

   // One transaction per clock: drive, check combinational outputs and the
   // sticky bit left by the previous edge, then advance the sticky model.
   task automatic do_op(input string name, input logic rst, input logic [1:0] op,
                        input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic [31:0] pc);
      logic [3:0]  e_ctl;
      logic [31:0] e_res;
      logic        e_co, e_ov;
      @(posedge clk);
      #1;
      reset = rst; alu_op = op; funct = fn; a = x; b = y; cin = ci; pc_in = pc;
      #1;
      e_ctl = ref_ctl(op, fn);
      ref_alu(e_ctl, x, y, ci, e_res, e_co, e_ov);
      check({name, ".ctl"},    {28'd0, alu_ctl}, {28'd0, e_ctl});
      check({name, ".res"},    alu_res, e_res);
      check({name, ".zero"},   {31'd0, zero}, {31'd0, e_res == 32'd0});
      check({name, ".cout"},   {31'd0, cout}, {31'd0, e_co});
      check({name, ".ovf"},    {31'd0, ovf}, {31'd0, e_ov});
      check({name, ".pc"},     pc_sum, pc + 32'd4);
      check({name, ".sticky"}, {31'd0, ovf_sticky}, {31'd0, exp_sticky});
      $display("%s op=%b fn=%h a=%h b=%h cin=%b -> ctl=%h res=%h z=%b c=%b v=%b s=%b",
               name, op, fn, x, y, ci, alu_ctl, alu_res, zero, cout, ovf, ovf_sticky);
      exp_sticky = rst ? 1'b0 : (exp_sticky | e_ov);
   endtask

   initial begin
      logic [5:0]  fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
      logic [31:0] edges [6] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h5};
      reset = 1'b1; alu_op = 2'b00; funct = 6'h00; a = 32'd0; b = 32'd0; cin = 1'b0; pc_in = 32'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset.sticky", {31'd0, ovf_sticky}, 32'd0);

      // Decode sweep over every alu_op and every listed funct.
      for (int i = 0; i < 4; i++)
         do_op("dec_op", 1'b0, 2'(i), 6'h3F, 32'h1234, 32'h0034, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++)
         do_op("dec_fn", 1'b0, 2'b10, fns[i], 32'h00F0, 32'h00FF, 1'b0, 32'h0);
      check("dec_fn0.ctl", {28'd0, alu_ctl}, 32'h2);

      do_op("add_ovf", 1'b0, 2'b00, 6'h00, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h00400000);
      check("add_ovf.res_lit", alu_res, 32'h80000000);
      check("add_ovf.ovf_lit", {31'd0, ovf}, 32'd1);
      check("pc.lit", pc_sum, 32'h00400004);
      do_op("add_wrap", 1'b0, 2'b00, 6'h00, 32'hFFFFFFFF, 32'h1, 1'b0, 32'hFFFFFFFC);
      check("sticky.lit", {31'd0, ovf_sticky}, 32'd1);
      check("add_wrap.res_lit", alu_res, 32'h0);
      check("add_wrap.cout_lit", {31'd0, cout}, 32'd1);
      check("pc_wrap.lit", pc_sum, 32'h0);
      do_op("add_cin", 1'b0, 2'b00, 6'h00, 32'h10, 32'h20, 1'b1, 32'h0);
      check("add_cin.res_lit", alu_res, 32'h31);
      do_op("sub_eq", 1'b0, 2'b01, 6'h00, 32'h5, 32'h5, 1'b1, 32'h0);
      check("sub_eq.zero_lit", {31'd0, zero}, 32'd1);
      do_op("sub_ovf", 1'b0, 2'b01, 6'h00, 32'h80000000, 32'h1, 1'b0, 32'h0);
      check("sub_ovf.res_lit", alu_res, 32'h7FFFFFFF);
      do_op("slt_neg", 1'b0, 2'b11, 6'h00, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0);
      check("slt_neg.res_lit", alu_res, 32'h1);
      do_op("slt_big", 1'b0, 2'b11, 6'h00, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'h0);
      check("slt_big.res_lit", alu_res, 32'h0);
      do_op("and", 1'b0, 2'b10, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0);
      check("and.lit", alu_res, 32'hF000F000);
      do_op("or", 1'b0, 2'b10, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0);
      check("or.lit", alu_res, 32'hFFF0FFF0);
      do_op("xor", 1'b0, 2'b10, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0);
      check("xor.lit", alu_res, 32'h0FF00FF0);
      do_op("nor", 1'b0, 2'b10, 6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0);
      check("nor.lit", alu_res, 32'h000F000F);

      // Clear the sticky bit, then assert reset together with an overflow.
      do_op("rst_clr", 1'b1, 2'b10, 6'h24, 32'h0, 32'h0, 1'b0, 32'h0);
      do_op("rst_ovf", 1'b1, 2'b00, 6'h00, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h0);
      do_op("post_rst", 1'b0, 2'b10, 6'h25, 32'h1, 32'h2, 1'b0, 32'h0);
      check("rst_prio.lit", {31'd0, ovf_sticky}, 32'd0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] x, y;
         x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         do_op("rnd", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 0) ? fns[$urandom_range(0, 9)] : 6'($urandom),
               x, y, 1'($urandom), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
